// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high/low/period of a divided clock in clk cycles and checks it against an expected ratio
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 4,
  parameter bit DUTY_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_clk_in,
  input  logic [CNT_W:0]   expected_div,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  state_t state, state_d;
  logic s1, s2, s3;
  logic [CNT_W-1:0] hcnt, lcnt, diff;
  logic [CNT_W:0] sum;
  logic [3:0] match_cnt;
  logic rise, fall, cap, sat, match;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign sum = {1'b0, hcnt} + {1'b0, lcnt};
  assign diff = hcnt >= lcnt ? hcnt - lcnt : lcnt - hcnt;
  assign match = (sum == expected_div) && (!DUTY_CHECK || diff <= ONE);
  // two-flop synchronizer plus history flop for edge detection, free-running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {div_clk_in, s1, s2};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // next state, capture strobe and saturation detect; an edge beats saturation
  always_comb begin
    state_d = state;
    cap = 1'b0;
    sat = 1'b0;
    if (!en) state_d = IDLE;
    else case (state)
      IDLE:      state_d = WAIT_RISE;
      WAIT_RISE: state_d = rise ? MEAS_HIGH : WAIT_RISE;
      MEAS_HIGH: begin
        sat = !fall && hcnt == CNT_MAX;
        state_d = fall ? MEAS_LOW : sat ? WAIT_RISE : MEAS_HIGH;
      end
      MEAS_LOW: begin
        cap = rise;
        sat = !rise && lcnt == CNT_MAX;
        state_d = rise ? MEAS_HIGH : sat ? WAIT_RISE : MEAS_LOW;
      end
      default: state_d = IDLE;
    endcase
  end
  // high/low phase counters; cleared on disable or saturation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt <= '0;
      lcnt <= '0;
    end else if (!en || sat) begin
      hcnt <= '0;
      lcnt <= '0;
    end else case (state)
      WAIT_RISE: if (rise) hcnt <= ONE;
      MEAS_HIGH: if (fall) lcnt <= ONE; else hcnt <= hcnt + ONE;
      MEAS_LOW:  if (rise) hcnt <= ONE; else lcnt <= lcnt + ONE;
      default: ;
    endcase
  // measurement capture, pulses and lock tracking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      high_len <= '0;
      low_len <= '0;
      period <= '0;
      meas_valid <= 1'b0;
      err <= 1'b0;
      timeout <= 1'b0;
      locked <= 1'b0;
      match_cnt <= '0;
    end else begin
      meas_valid <= cap;
      err <= cap & ~match;
      timeout <= sat;
      if (cap) begin
        high_len <= hcnt;
        low_len <= lcnt;
        period <= sum;
      end
      if (!en || sat || (cap && !match)) begin
        locked <= 1'b0;
        match_cnt <= '0;
      end else if (cap) begin
        match_cnt <= match_cnt >= LOCK_N ? LOCK_N : match_cnt + 4'd1;
        if (match_cnt >= LOCK_N - 4'd1) locked <= 1'b1;
      end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: randomized and directed stimulus against a timestamp-based reference model
module tb_clk_div_monitor;
  localparam int CNT_W = 8;
  localparam int LOCK_CNT = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic div = 1'b0;
  logic [CNT_W:0] exp_div = '0;
  logic [CNT_W-1:0] high_len, low_len;
  logic [CNT_W:0] period;
  logic meas_valid, locked, err, timeout;
  int errors = 0, checks = 0, to_seen = 0;
  int d1, d2, d3, mode, n = 0, t_rise, t_fall, mc;
  int e_mv, e_err, e_to, e_lk, e_hl, e_ll, e_per;

  always #5 clk = ~clk;

  clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .DUTY_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_clk_in(div), .expected_div(exp_div),
    .high_len(high_len), .low_len(low_len), .period(period), .meas_valid(meas_valid),
    .locked(locked), .err(err), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    d1 = 0; d2 = 0; d3 = 0; mode = 0; mc = 0;
    e_mv = 0; e_err = 0; e_to = 0; e_lk = 0; e_hl = 0; e_ll = 0; e_per = 0;
  endtask

  // mode: 0 off, 1 waiting for first rise, 2 high phase, 3 low phase; lengths come from edge timestamps
  task automatic model_step();
    bit rise, fall;
    int h, l;
    n++;
    rise = d2 == 1 && d3 == 0;
    fall = d2 == 0 && d3 == 1;
    e_mv = 0; e_err = 0; e_to = 0;
    if (!en) begin
      mode = 0; mc = 0; e_lk = 0;
    end else if (mode == 0) mode = 1;
    else if (mode == 1) begin
      if (rise) begin mode = 2; t_rise = n; end
    end else if (mode == 2) begin
      if (fall) begin mode = 3; t_fall = n; end
      else if (n - t_rise == SAT) begin e_to = 1; mode = 1; mc = 0; e_lk = 0; end
    end else begin
      if (rise) begin
        h = t_fall - t_rise;
        l = n - t_fall;
        e_hl = h; e_ll = l; e_per = h + l; e_mv = 1;
        if (e_per == int'(exp_div) && h - l <= 1 && l - h <= 1) begin
          mc = mc < LOCK_CNT ? mc + 1 : LOCK_CNT;
          if (mc == LOCK_CNT) e_lk = 1;
        end else begin
          mc = 0; e_lk = 0; e_err = 1;
        end
        t_rise = n; mode = 2;
      end else if (n - t_fall == SAT) begin e_to = 1; mode = 1; mc = 0; e_lk = 0; end
    end
    d3 = d2; d2 = d1; d1 = int'(div);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (timeout) to_seen++;
    chk("meas_valid", 32'(meas_valid), e_mv);
    chk("err", 32'(err), e_err);
    chk("timeout", 32'(timeout), e_to);
    chk("locked", 32'(locked), e_lk);
    chk("high_len", 32'(high_len), e_hl);
    chk("low_len", 32'(low_len), e_ll);
    chk("period", 32'(period), e_per);
  endtask

  task automatic wave(input int hi, input int lo, input int k);
    repeat (k) begin
      div = 1'b1;
      repeat (hi) tick();
      div = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic check_zero();
    chk("rst_high_len", 32'(high_len), 0);
    chk("rst_low_len", 32'(low_len), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_timeout", 32'(timeout), 0);
  endtask

  initial begin
    int hi, lo;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero();
    rst_n = 1'b1;
    en = 1'b1;
    exp_div = 9'd2;
    wave(1, 1, 12);
    chk("t1_locked", 32'(locked), 1);
    exp_div = 9'd5;
    wave(3, 2, 8);
    chk("t2_locked", 32'(locked), 1);
    wave(4, 1, 4);
    chk("t2_unlocked", 32'(locked), 0);
    exp_div = 9'd2;
    wave(1, 1, 8);
    wave(2, 2, 2);
    exp_div = 9'd4;
    wave(2, 2, 6);
    chk("t3_relocked", 32'(locked), 1);
    to_seen = 0;
    div = 1'b1;
    repeat (300) tick();
    chk("t4_timeouts", to_seen, 1);
    chk("t4_locked", 32'(locked), 0);
    wave(2, 2, 4);
    exp_div = 9'd6;
    wave(3, 3, 3);
    div = 1'b1;
    repeat (3) tick();
    div = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;
    wave(3, 3, 4);
    exp_div = 9'd2;
    wave(1, 1, 6);
    chk("t6_locked", 32'(locked), 1);
    en = 1'b0;
    wave(1, 1, 3);
    chk("t6_dropped", 32'(locked), 0);
    en = 1'b1;
    wave(1, 1, 6);
    for (int i = 0; i < 60; i++) begin
      hi = $urandom_range(1, 6);
      lo = $urandom_range(1, 6);
      if ($urandom_range(0, 14) == 0) hi = $urandom_range(SAT - 2, SAT + 2);
      if ($urandom_range(0, 14) == 0) lo = $urandom_range(SAT - 2, SAT + 2);
      exp_div = $urandom_range(0, 3) == 0 ? 9'($urandom_range(0, 14)) : 9'(hi + lo);
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        en = 1'b1;
      end
      wave(hi, lo, $urandom_range(1, 5));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
